// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues single-outstanding word reads
// and buffers {pc,inst} pairs for the IDU. Optional perf counters under IFU_PERF_COUNT_EN.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt,
  output logic [1:0]  o_fsm_state
);

  // Handshakes: a memory request transfers when o_mem_req & i_mem_gnt at a clock edge;
  // an instruction transfers to the IDU when o_valid & i_ready (and no redirect that cycle).
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc_q;
  logic [31:0]   fetch_pc;
  logic          drop;

  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic [PW:0]   cnt_next;
  logic          push;
  logic          pop;

  assign o_valid     = (cnt != '0);
  assign o_inst      = fifo_inst[rd_ptr];
  assign o_pc        = fifo_pc[rd_ptr];
  assign o_mem_addr  = pc_q;
  assign o_fsm_state = state;

  // A redirect flushes the buffer, so neither a pop nor a push survives it.
  assign pop      = o_valid && i_ready && !i_redirect;
  assign push     = (state == ST_WAIT) && i_mem_rvalid && !drop && !i_redirect;
  assign cnt_next = cnt + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_mem_req <= 1'b0;
      pc_q      <= RESET_PC & ~32'h3;
      fetch_pc  <= '0;
      drop      <= 1'b0;
    end else if (i_redirect) begin
      pc_q <= i_redirect_pc & ~32'h3;
      case (state)
        ST_IDLE: begin
          state     <= ST_REQ;
          o_mem_req <= 1'b1;
        end
        ST_REQ: begin
          // A read granted in this cycle is still owed a response; swallow it.
          if (i_mem_gnt) begin
            state     <= ST_WAIT;
            o_mem_req <= 1'b0;
            drop      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            state     <= ST_REQ;
            o_mem_req <= 1'b1;
            drop      <= 1'b0;
          end else begin
            drop <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (cnt < DEPTH_C) begin
            state     <= ST_REQ;
            o_mem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_mem_gnt) begin
            fetch_pc  <= pc_q;
            pc_q      <= pc_q + 32'd4;
            state     <= ST_WAIT;
            o_mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            drop <= 1'b0;
            if (cnt_next < DEPTH_C) begin
              state     <= ST_REQ;
              o_mem_req <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              o_mem_req <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (i_redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= fetch_pc;
        fifo_inst[wr_ptr] <= i_mem_rdata;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt_next;
    end
  end

`ifdef IFU_PERF_COUNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fetch_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (pop) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end
      if (!o_valid) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`else
  assign o_fetch_cnt = 32'h0;
  assign o_stall_cnt = 32'h0;
`endif

endmodule
